fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - reset-vector load and byte-stream fetch unit; optional write port via FETCH_UNIT_WRITE_PORT_EN
module fetch_unit #(
    parameter int                DEPTH        = 16,
    parameter int                WIDTH        = 8,
    parameter logic [DEPTH-1:0]  RESET_VECTOR = DEPTH'(16'hFFFC)
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             enable,
    output logic [DEPTH-1:0] address,
    output logic             wr_enable,
    output logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] rd_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [WIDTH-1:0] byte_data,
    output logic [DEPTH-1:0] byte_addr,
    input  logic             jump_valid,
    input  logic [DEPTH-1:0] jump_addr,
    output logic             vector_done,
    output logic [DEPTH-1:0] pc
`ifdef FETCH_UNIT_WRITE_PORT_EN
    ,
    input  logic             wr_req,
    input  logic [DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_din,
    output logic             wr_ack
`endif
);

    typedef enum logic [1:0] {VEC_LO, VEC_HI, VEC_WAIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] vec_lo_q, vec_lo_d;
    logic [DEPTH-1:0] pc_q, pc_d;
    logic             vector_done_q, vector_done_d;
    logic             inflight_q, inflight_d;
    logic [DEPTH-1:0] inflight_addr_q, inflight_addr_d;
    logic [WIDTH-1:0] fifo_data_q [2];
    logic [WIDTH-1:0] fifo_data_d [2];
    logic [DEPTH-1:0] fifo_addr_q [2];
    logic [DEPTH-1:0] fifo_addr_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic             en_c;
    logic [DEPTH-1:0] addr_c;
    logic             pop, push, flush, issue;
    logic [1:0]       occupancy;
`ifdef FETCH_UNIT_WRITE_PORT_EN
    logic             wr_en_c;
    logic [WIDTH-1:0] wr_data_c;
    logic             wr_ack_c;
`endif

    assign byte_valid = (count_q != 2'd0);
    assign pop        = byte_valid && byte_ready;
    // Buffered plus in-flight bytes once this cycle's handshake retires.
    assign occupancy  = count_q + 2'(inflight_q) - 2'(pop);

    always_comb begin
        state_d         = state_q;
        vec_lo_d        = vec_lo_q;
        pc_d            = pc_q;
        vector_done_d   = vector_done_q;
        en_c            = 1'b0;
        addr_c          = pc_q;
        flush           = 1'b0;
        issue           = 1'b0;
`ifdef FETCH_UNIT_WRITE_PORT_EN
        wr_en_c         = 1'b0;
        wr_data_c       = '0;
        wr_ack_c        = 1'b0;
`endif
        case (state_q)
            VEC_LO: begin
                en_c    = 1'b1;
                addr_c  = RESET_VECTOR;
                state_d = VEC_HI;
            end
            VEC_HI: begin
                en_c     = 1'b1;
                addr_c   = RESET_VECTOR + DEPTH'(1);
                vec_lo_d = rd_data;
                state_d  = VEC_WAIT;
            end
            VEC_WAIT: begin
                pc_d          = DEPTH'({rd_data, vec_lo_q});
                vector_done_d = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                flush = jump_valid;
`ifdef FETCH_UNIT_WRITE_PORT_EN
                if (wr_req) begin
                    en_c      = 1'b1;
                    addr_c    = wr_addr;
                    wr_en_c   = 1'b1;
                    wr_data_c = wr_din;
                    wr_ack_c  = 1'b1;
                end else
`endif
                if (!jump_valid && (occupancy < 2'd2)) begin
                    en_c   = 1'b1;
                    addr_c = pc_q;
                    pc_d   = pc_q + DEPTH'(1);
                    issue  = 1'b1;
                end
                if (jump_valid) begin
                    pc_d = jump_addr;
                end
            end
            default: state_d = VEC_LO;
        endcase
    end

    // A read issued last cycle returns now; a jump discards it along with the FIFO.
    always_comb begin
        push            = inflight_q && !flush;
        inflight_d      = issue;
        inflight_addr_d = issue ? pc_q : inflight_addr_q;
        fifo_data_d     = fifo_data_q;
        fifo_addr_d     = fifo_addr_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = rd_data;
                fifo_addr_d[wr_ptr_q] = inflight_addr_q;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= VEC_LO;
            vec_lo_q        <= '0;
            pc_q            <= '0;
            vector_done_q   <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_addr_q[0]  <= '0;
            fifo_addr_q[1]  <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            vec_lo_q        <= vec_lo_d;
            pc_q            <= pc_d;
            vector_done_q   <= vector_done_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            fifo_data_q     <= fifo_data_d;
            fifo_addr_q     <= fifo_addr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    // Reset clears state asynchronously, but VEC_LO would still strobe; gate it directly.
    assign enable      = en_c && resetn;
    assign address     = addr_c;
    assign byte_data   = fifo_data_q[rd_ptr_q];
    assign byte_addr   = fifo_addr_q[rd_ptr_q];
    assign vector_done = vector_done_q;
    assign pc          = pc_q;
`ifdef FETCH_UNIT_WRITE_PORT_EN
    assign wr_enable   = wr_en_c && resetn;
    assign wr_data     = wr_data_c;
    assign wr_ack      = wr_ack_c && resetn;
`else
    assign wr_enable   = 1'b0;
    assign wr_data     = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] address;
    logic        wr_enable;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic [15:0] byte_addr;
    logic        jump_valid;
    logic [15:0] jump_addr;
    logic        vector_done;
    logic [15:0] pc;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_din;
    logic        wr_ack;

    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .address     (address),
        .wr_enable   (wr_enable),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .byte_addr   (byte_addr),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .vector_done (vector_done),
        .pc          (pc)
`ifdef FETCH_UNIT_WRITE_PORT_EN
        ,
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_din      (wr_din),
        .wr_ack      (wr_ack)
`endif
    );

`ifndef FETCH_UNIT_WRITE_PORT_EN
    assign wr_ack = 1'b0;
`endif

    always @(posedge clk) begin
        if (enable) begin
            if (wr_enable) mem[address] = wr_data;
            else           rd_data <= mem[address];
        end
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %h want 0", enable); end
        checks++; if (wr_enable !== 1'b0) begin errors++; $display("FAIL rst_wr_enable got %h want 0", wr_enable); end
        checks++; if (address !== 16'hFFFC) begin errors++; $display("FAIL rst_address got %h want fffc", address); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data got %h want 00", wr_data); end
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rst_byte_valid got %h want 0", byte_valid); end
        checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL rst_byte_data got %h want 00", byte_data); end
        checks++; if (byte_addr !== 16'h0000) begin errors++; $display("FAIL rst_byte_addr got %h want 0000", byte_addr); end
        checks++; if (vector_done !== 1'b0) begin errors++; $display("FAIL rst_vector_done got %h want 0", vector_done); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h want 0000", pc); end
    endtask

    task automatic test_vector();
        resetn = 1'b1;
        #1;
        checks++; if (enable !== 1'b1 || address !== 16'hFFFC) begin errors++; $display("FAIL vec_lo got en=%h addr=%h want en=1 addr=fffc", enable, address); end
        tick();
        checks++; if (enable !== 1'b1 || address !== 16'hFFFD) begin errors++; $display("FAIL vec_hi got en=%h addr=%h want en=1 addr=fffd", enable, address); end
        checks++; if (vector_done !== 1'b0) begin errors++; $display("FAIL vec_done_early1 got %h want 0", vector_done); end
        tick();
        checks++; if (vector_done !== 1'b0) begin errors++; $display("FAIL vec_done_early2 got %h want 0", vector_done); end
        tick();
        checks++; if (vector_done !== 1'b1) begin errors++; $display("FAIL vec_done got %h want 1", vector_done); end
        checks++; if (pc !== 16'hC000) begin errors++; $display("FAIL vec_pc got %h want c000", pc); end
        tick();
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early got %h want 0", byte_valid); end
        tick();
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hA9 || byte_addr !== 16'hC000) begin errors++; $display("FAIL first_byte got v=%h %h@%h want v=1 a9@c000", byte_valid, byte_data, byte_addr); end
        tick();
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF || byte_addr !== 16'hC001) begin errors++; $display("FAIL second_byte got v=%h %h@%h want v=1 ff@c001", byte_valid, byte_data, byte_addr); end
    endtask

    task automatic test_stall();
        byte_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (enable !== 1'b0) begin errors++; $display("FAIL stall_no_issue cycle %0d got en=%h want 0", i, enable); end
            tick();
            checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF || byte_addr !== 16'hC001) begin errors++; $display("FAIL stall_hold cycle %0d got v=%h %h@%h want v=1 ff@c001", i, byte_valid, byte_data, byte_addr); end
        end
        byte_ready = 1'b1;
        for (int k = 2; k < 6; k++) begin
            logic [15:0] a;
            a = 16'hC000 + 16'(k);
            tick();
            checks++; if (byte_valid !== 1'b1 || byte_data !== pat(a) || byte_addr !== a) begin errors++; $display("FAIL stall_resume got v=%h %h@%h want v=1 %h@%h", byte_valid, byte_data, byte_addr, pat(a), a); end
        end
    endtask

    task automatic test_jump();
        int n;
        byte_ready = 1'b0;
        tick();
        tick();
        jump_valid = 1'b1;
        jump_addr  = 16'h8000;
        tick();
        jump_valid = 1'b0;
        checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL jump_flush got v=%h want 0", byte_valid); end
        byte_ready = 1'b1;
        n = 0;
        while (byte_valid !== 1'b1 && n < 8) begin tick(); n++; end
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hEA || byte_addr !== 16'h8000) begin errors++; $display("FAIL jump_first got v=%h %h@%h want v=1 ea@8000", byte_valid, byte_data, byte_addr); end
        tick();
        checks++; if (byte_valid !== 1'b1 || byte_data !== pat(16'h8001) || byte_addr !== 16'h8001) begin errors++; $display("FAIL jump_second got v=%h %h@%h want v=1 %h@8001", byte_valid, byte_data, byte_addr, pat(16'h8001)); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        tick();
        resetn = 1'b0;
        #1;
        checks++; if (enable !== 1'b0 || wr_enable !== 1'b0 || address !== 16'hFFFC) begin errors++; $display("FAIL midrst_bus got en=%h we=%h addr=%h want 0 0 fffc", enable, wr_enable, address); end
        checks++; if (byte_valid !== 1'b0 || byte_data !== 8'h00 || byte_addr !== 16'h0000) begin errors++; $display("FAIL midrst_byte got v=%h %h@%h want v=0 00@0000", byte_valid, byte_data, byte_addr); end
        checks++; if (vector_done !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL midrst_state got done=%h pc=%h want 0 0000", vector_done, pc); end
        tick();
        resetn = 1'b1;
        #1;
        checks++; if (enable !== 1'b1 || address !== 16'hFFFC) begin errors++; $display("FAIL midrst_refetch_lo got en=%h addr=%h want 1 fffc", enable, address); end
        tick();
        checks++; if (address !== 16'hFFFD) begin errors++; $display("FAIL midrst_refetch_hi got addr=%h want fffd", address); end
        tick();
        tick();
        checks++; if (vector_done !== 1'b1 || pc !== 16'hC000) begin errors++; $display("FAIL midrst_vector got done=%h pc=%h want 1 c000", vector_done, pc); end
        n = 0;
        while (byte_valid !== 1'b1 && n < 8) begin tick(); n++; end
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hA9 || byte_addr !== 16'hC000) begin errors++; $display("FAIL midrst_first got v=%h %h@%h want v=1 a9@c000", byte_valid, byte_data, byte_addr); end
    endtask

    task automatic test_wrap();
        int n;
        resetn = 1'b0;
        mem[16'hFFFC] = 8'hFF;
        mem[16'hFFFD] = 8'hFF;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        tick();
        resetn     = 1'b1;
        jump_valid = 1'b1;
        jump_addr  = 16'h1234;
        tick();
        tick();
        tick();
        jump_valid = 1'b0;
        checks++; if (vector_done !== 1'b1 || pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_vector got done=%h pc=%h want 1 ffff", vector_done, pc); end
        n = 0;
        while (byte_valid !== 1'b1 && n < 8) begin tick(); n++; end
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'h11 || byte_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_first got v=%h %h@%h want v=1 11@ffff", byte_valid, byte_data, byte_addr); end
        tick();
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'h22 || byte_addr !== 16'h0000) begin errors++; $display("FAIL wrap_second got v=%h %h@%h want v=1 22@0000", byte_valid, byte_data, byte_addr); end
    endtask

`ifdef FETCH_UNIT_WRITE_PORT_EN
    task automatic test_write();
        int n;
        wr_req  = 1'b1;
        wr_addr = 16'h8000;
        wr_din  = 8'hFF;
        #1;
        checks++; if (wr_ack !== 1'b1 || enable !== 1'b1 || wr_enable !== 1'b1) begin errors++; $display("FAIL write_strobe got ack=%h en=%h we=%h want 1 1 1", wr_ack, enable, wr_enable); end
        checks++; if (address !== 16'h8000 || wr_data !== 8'hFF) begin errors++; $display("FAIL write_bus got addr=%h data=%h want 8000 ff", address, wr_data); end
        tick();
        wr_req = 1'b0;
        #1;
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL write_ack_pulse got %h want 0", wr_ack); end
        jump_valid = 1'b1;
        jump_addr  = 16'h8000;
        tick();
        jump_valid = 1'b0;
        n = 0;
        while (byte_valid !== 1'b1 && n < 8) begin tick(); n++; end
        checks++; if (byte_valid !== 1'b1 || byte_data !== 8'hFF || byte_addr !== 16'h8000) begin errors++; $display("FAIL write_readback got v=%h %h@%h want v=1 ff@8000", byte_valid, byte_data, byte_addr); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hC0;
        mem[16'hC000] = 8'hA9;
        mem[16'hC001] = 8'hFF;
        mem[16'h8000] = 8'hEA;
        rd_data    = 8'h00;
        resetn     = 1'b0;
        byte_ready = 1'b1;
        jump_valid = 1'b0;
        jump_addr  = 16'h0000;
        wr_req     = 1'b0;
        wr_addr    = 16'h0000;
        wr_din     = 8'h00;
        tick();
        tick();
        test_reset();
        test_vector();
        test_stall();
        test_jump();
        test_reset_mid_run();
        test_wrap();
`ifdef FETCH_UNIT_WRITE_PORT_EN
        test_write();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
